// File: rtl/id_ex_dispatch_fifo.sv
// rtl/id_ex_dispatch_fifo.sv - decode->dispatch bundle buffer with stall, flush and occupancy
module id_ex_dispatch_fifo #(
    parameter int DATA_W = 100,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       stall,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic                       is_dispatching,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic [CNT_W-1:0]           dispatch_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;

    assign full           = (count == CW'(DEPTH));
    assign empty          = (count == '0);
    assign in_ready       = ~full;
    assign out_valid      = ~empty & ~stall;
    assign out_data       = mem[rd_ptr];
    assign push           = in_valid & in_ready & ~flush;
    assign pop            = out_valid & out_ready;
    assign is_dispatching = pop;

    // Pointers wrap on their own because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // A dispatch in a flush cycle has already left the buffer, so it is still counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            dispatch_cnt <= '0;
        end else if (pop) begin
            dispatch_cnt <= dispatch_cnt + CNT_W'(1);
        end
    end

    a_push_ready: assert property (@(posedge clk) disable iff (rst) push |-> in_ready);
    a_pop_valid:  assert property (@(posedge clk) disable iff (rst) pop |-> out_valid);
    a_count_max:  assert property (@(posedge clk) disable iff (rst) count <= CW'(DEPTH));
endmodule

// File: tb/tb_id_ex_dispatch_fifo.sv
// tb/tb_id_ex_dispatch_fifo.sv - self-checking bench for id_ex_dispatch_fifo against a queue model
module tb_id_ex_dispatch_fifo;
    localparam int DATA_W = 100;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 32;

    logic                   clk;
    logic                   rst;
    logic                   flush;
    logic                   stall;
    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_W-1:0]      in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_W-1:0]      out_data;
    logic                   is_dispatching;
    logic [$clog2(DEPTH):0] count;
    logic                   full;
    logic                   empty;
    logic [CNT_W-1:0]       dispatch_cnt;

    id_ex_dispatch_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .is_dispatching(is_dispatching), .count(count), .full(full), .empty(empty),
        .dispatch_cnt(dispatch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] model_q [$];
    logic [CNT_W-1:0]  model_cnt;
    int                n_checks;
    int                n_fails;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        return r[DATA_W-1:0];
    endfunction

    // Drive one cycle from a negedge, check every output against the model, then advance the model.
    task automatic cycle(input logic r, input logic f, input logic s, input logic iv,
                         input logic ordy, input logic [DATA_W-1:0] d);
        bit exp_ov;
        bit do_push;
        bit do_pop;
        rst = r; flush = f; stall = s; in_valid = iv; out_ready = ordy; in_data = d;
        #1;
        exp_ov = (model_q.size() > 0) && !s;
        check("out_valid", 128'(out_valid), 128'(exp_ov));
        check("is_dispatching", 128'(is_dispatching), 128'(exp_ov && ordy));
        check("in_ready", 128'(in_ready), 128'(model_q.size() < DEPTH));
        check("count", 128'(count), 128'(model_q.size()));
        check("full", 128'(full), 128'(model_q.size() == DEPTH));
        check("empty", 128'(empty), 128'(model_q.size() == 0));
        check("dispatch_cnt", 128'(dispatch_cnt), 128'(model_cnt));
        if (model_q.size() > 0) check("out_data", 128'(out_data), 128'(model_q[0]));
        do_push = iv && (model_q.size() < DEPTH) && !f;
        do_pop  = exp_ov && ordy;
        @(posedge clk);
        if (r) begin
            model_q.delete();
            model_cnt = '0;
        end else begin
            if (do_pop) begin
                void'(model_q.pop_front());
                model_cnt = model_cnt + 1;
            end
            if (f) model_q.delete();
            else if (do_push) model_q.push_back(d);
        end
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0; n_fails = 0; model_cnt = '0;
        rst = 1'b1; flush = 1'b0; stall = 1'b0; in_valid = 1'b1; out_ready = 1'b0; in_data = '0;
        @(negedge clk);

        // Reset held two cycles with in_valid asserted
        cycle(1, 0, 0, 1, 0, rand_data());
        cycle(1, 0, 0, 1, 0, rand_data());
        in_valid = 1'b0; #1;
        check("reset_out_data", 128'(out_data), 128'(0));
        check("reset_count", 128'(count), 128'(0));

        // Fill A..D then a rejected fifth, then drain in order
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 0, DATA_W'(32'hA0 + i));
        check("fill_full", 128'(full), 128'(1));
        check("fill_in_ready", 128'(in_ready), 128'(0));
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1, '0);
        check("drain_cnt", 128'(dispatch_cnt), 128'(4));
        check("drain_empty", 128'(empty), 128'(1));

        // Stall with two held, one push during stall
        cycle(0, 0, 0, 1, 0, DATA_W'(32'hB0));
        cycle(0, 0, 0, 1, 0, DATA_W'(32'hB1));
        cycle(0, 0, 1, 1, 1, DATA_W'(32'hB2));
        cycle(0, 0, 1, 0, 1, '0);
        cycle(0, 0, 1, 0, 1, '0);
        check("stall_count", 128'(count), 128'(3));
        for (int i = 0; i < 2; i++) cycle(0, 0, 0, 0, 1, '0);

        // Flush with simultaneous push and pop at count 3
        cycle(0, 0, 0, 1, 0, DATA_W'(32'hC0));
        cycle(0, 0, 0, 1, 0, DATA_W'(32'hC1));
        check("pre_flush_count", 128'(count), 128'(3));
        cycle(0, 1, 0, 1, 1, DATA_W'(32'hDEAD));
        check("flush_count", 128'(count), 128'(0));
        check("flush_cnt", 128'(dispatch_cnt), 128'(7));

        // Steady stream across pointer wrap
        for (int i = 0; i < 20; i++) cycle(0, 0, 0, 1, 1, DATA_W'(32'hE00 + i));
        cycle(0, 0, 0, 0, 1, '0);
        check("stream_cnt", 128'(dispatch_cnt), 128'(27));

        // Full plus simultaneous pop: push rejected, accepted next cycle
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0, DATA_W'(32'hF0 + i));
        cycle(0, 0, 0, 1, 1, DATA_W'(32'hF8));
        check("fullpop_count", 128'(count), 128'(DEPTH - 1));
        cycle(0, 0, 0, 1, 0, DATA_W'(32'hF9));
        check("fullpop_refill", 128'(count), 128'(DEPTH));

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(63) == 0), ($urandom_range(15) == 0), ($urandom_range(3) == 0),
                  1'($urandom_range(1)), 1'($urandom_range(1)), rand_data());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
